// File: rtl/run_monitor_pkg.sv
// Shared types for the run supervisor: per-channel stop status, FSM states
// and the width helper for the channel readout select.
package run_monitor_pkg;

    typedef enum logic [1:0] {
        ST_RUNNING = 2'd0,
        ST_HALTED  = 2'd1,
        ST_ERROR   = 2'd2,
        ST_TIMEOUT = 2'd3
    } chan_status_t;

    typedef enum logic [1:0] {
        FSM_IDLE = 2'd0,
        FSM_RUN  = 2'd1,
        FSM_DONE = 2'd2
    } fsm_state_t;

    // A single channel still needs a 1-bit select port.
    function automatic int sel_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/run_monitor_channel.sv
// One supervised core: latches how and when it stopped, and counts LED
// toggles while it is still running.
module run_monitor_channel
    import run_monitor_pkg::*;
#(
    parameter int CYCLE_BITS  = 16,
    parameter int TOGGLE_BITS = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   active,
    input  logic                   nhlt,
    input  logic                   nerror,
    input  logic                   led,
    input  logic [CYCLE_BITS-1:0]  cycle,
    input  logic                   timeout_hit,
    output chan_status_t           status_o,
    output chan_status_t           status_next_o,
    output logic [CYCLE_BITS-1:0]  stop_cycle_o,
    output logic [TOGGLE_BITS-1:0] toggles_o
);

    chan_status_t           status_q, status_d;
    logic [CYCLE_BITS-1:0]  stop_cycle_q, stop_cycle_d;
    logic [TOGGLE_BITS-1:0] toggles_q, toggles_d;
    logic                   led_prev_q;

    always_comb begin
        status_d     = status_q;
        stop_cycle_d = stop_cycle_q;
        toggles_d    = toggles_q;
        if (clear) begin
            status_d     = ST_RUNNING;
            stop_cycle_d = '0;
            toggles_d    = '0;
        end else if (active && status_q == ST_RUNNING) begin
            // The stopping cycle still counts a toggle; error beats halt.
            if (led != led_prev_q && toggles_q != '1) begin
                toggles_d = toggles_q + 1'b1;
            end
            if (!nerror) begin
                status_d     = ST_ERROR;
                stop_cycle_d = cycle;
            end else if (!nhlt) begin
                status_d     = ST_HALTED;
                stop_cycle_d = cycle;
            end else if (timeout_hit) begin
                status_d     = ST_TIMEOUT;
                stop_cycle_d = cycle;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            status_q     <= ST_RUNNING;
            stop_cycle_q <= '0;
            toggles_q    <= '0;
            led_prev_q   <= 1'b0;
        end else begin
            status_q     <= status_d;
            stop_cycle_q <= stop_cycle_d;
            toggles_q    <= toggles_d;
            led_prev_q   <= led;
        end
    end

    assign status_o      = status_q;
    assign status_next_o = status_d;
    assign stop_cycle_o  = stop_cycle_q;
    assign toggles_o     = toggles_q;

endmodule

// File: rtl/run_monitor.sv
// Multi-core run supervisor: runs a bounded cycle window, records how each
// core stopped and produces a registered done/pass verdict.
module run_monitor
    import run_monitor_pkg::*;
#(
    parameter  int CHANNELS    = 4,
    parameter  int CYCLE_BITS  = 16,
    parameter  int TIMEOUT     = 1000,
    parameter  int TOGGLE_BITS = 8,
    localparam int SEL_BITS    = sel_bits(CHANNELS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [CHANNELS-1:0]    nhlt,
    input  logic [CHANNELS-1:0]    nerror,
    input  logic [CHANNELS-1:0]    led,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [CHANNELS-1:0]    fail_mask,
    input  logic [SEL_BITS-1:0]    sel,
    output logic [1:0]             sel_status,
    output logic [CYCLE_BITS-1:0]  sel_cycle,
    output logic [TOGGLE_BITS-1:0] sel_toggles,
    output fsm_state_t             dbg_state_o
);

    if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
        $error("run_monitor: CHANNELS must be 1..16");
    end
    if (TIMEOUT < 1 || longint'(TIMEOUT) >= (64'd1 << CYCLE_BITS)) begin : g_bad_timeout
        $error("run_monitor: TIMEOUT must be 1..2**CYCLE_BITS-1");
    end

    localparam logic [CYCLE_BITS-1:0] LAST_CYCLE = CYCLE_BITS'(TIMEOUT - 1);

    fsm_state_t            state_q;
    logic [CYCLE_BITS-1:0] cycle_q;
    logic                  busy_q, done_q, pass_q;
    logic [CHANNELS-1:0]   fail_mask_q;

    logic                  clear, active, timeout_hit, all_stopped;
    logic [CHANNELS-1:0]   fail_next;

    chan_status_t           status_a      [CHANNELS];
    chan_status_t           status_next_a [CHANNELS];
    logic [CYCLE_BITS-1:0]  stop_cycle_a  [CHANNELS];
    logic [TOGGLE_BITS-1:0] toggles_a     [CHANNELS];

    assign active      = (state_q == FSM_RUN);
    assign clear       = start && !active;
    assign timeout_hit = active && (cycle_q == LAST_CYCLE);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        run_monitor_channel #(
            .CYCLE_BITS  (CYCLE_BITS),
            .TOGGLE_BITS (TOGGLE_BITS)
        ) u_chan (
            .clk           (clk),
            .reset         (reset),
            .clear         (clear),
            .active        (active),
            .nhlt          (nhlt[i]),
            .nerror        (nerror[i]),
            .led           (led[i]),
            .cycle         (cycle_q),
            .timeout_hit   (timeout_hit),
            .status_o      (status_a[i]),
            .status_next_o (status_next_a[i]),
            .stop_cycle_o  (stop_cycle_a[i]),
            .toggles_o     (toggles_a[i])
        );
    end

    // Exit decision looks at the statuses this edge will write, so the
    // verdict lands together with the last captured stop.
    always_comb begin
        all_stopped = 1'b1;
        fail_next   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (status_next_a[i] == ST_RUNNING) begin
                all_stopped = 1'b0;
            end
            if (status_next_a[i] == ST_ERROR || status_next_a[i] == ST_TIMEOUT) begin
                fail_next[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FSM_IDLE;
            cycle_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_mask_q <= '0;
        end else begin
            case (state_q)
                FSM_IDLE, FSM_DONE: begin
                    if (start) begin
                        state_q     <= FSM_RUN;
                        cycle_q     <= '0;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        pass_q      <= 1'b0;
                        fail_mask_q <= '0;
                    end
                end
                FSM_RUN: begin
                    cycle_q <= cycle_q + 1'b1;
                    if (all_stopped || timeout_hit) begin
                        state_q     <= FSM_DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        fail_mask_q <= fail_next;
                        pass_q      <= (fail_next == '0);
                    end
                end
                default: begin
                    state_q <= FSM_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        int sel_idx;
        sel_idx     = int'(sel);
        sel_status  = '0;
        sel_cycle   = '0;
        sel_toggles = '0;
        if (sel_idx < CHANNELS) begin
            sel_status  = status_a[sel_idx];
            sel_cycle   = stop_cycle_a[sel_idx];
            sel_toggles = toggles_a[sel_idx];
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign fail_mask   = fail_mask_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_run_monitor.sv
// Directed bench for run_monitor: a 4-channel short-timeout instance with
// 2-bit toggle counters and a 1-channel instance with default widths.
module tb_run_monitor;

    logic       clk = 1'b0;
    logic       reset;

    logic       start;
    logic [3:0] nhlt, nerror, led;
    logic [1:0] sel;
    logic       busy, done, pass;
    logic [3:0] fail_mask;
    logic [1:0] sel_status;
    logic [7:0] sel_cycle;
    logic [1:0] sel_toggles;
    logic [1:0] dbg_state;

    logic        one_start;
    logic [0:0]  one_nhlt, one_nerror, one_led, one_sel;
    logic        one_busy, one_done, one_pass;
    logic [0:0]  one_fail_mask;
    logic [1:0]  one_sel_status;
    logic [15:0] one_sel_cycle;
    logic [7:0]  one_sel_toggles;
    logic [1:0]  one_dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    run_monitor #(
        .CHANNELS(4), .CYCLE_BITS(8), .TIMEOUT(20), .TOGGLE_BITS(2)
    ) u_dut (
        .clk(clk), .reset(reset), .start(start),
        .nhlt(nhlt), .nerror(nerror), .led(led),
        .busy(busy), .done(done), .pass(pass), .fail_mask(fail_mask),
        .sel(sel), .sel_status(sel_status), .sel_cycle(sel_cycle),
        .sel_toggles(sel_toggles), .dbg_state_o(dbg_state)
    );

    run_monitor #(
        .CHANNELS(1), .CYCLE_BITS(16), .TIMEOUT(20), .TOGGLE_BITS(8)
    ) u_one (
        .clk(clk), .reset(reset), .start(one_start),
        .nhlt(one_nhlt), .nerror(one_nerror), .led(one_led),
        .busy(one_busy), .done(one_done), .pass(one_pass), .fail_mask(one_fail_mask),
        .sel(one_sel), .sel_status(one_sel_status), .sel_cycle(one_sel_cycle),
        .sel_toggles(one_sel_toggles), .dbg_state_o(one_dbg_state)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_channel(input string tag, input int ch,
                                 input logic [1:0] st, input logic [7:0] cyc,
                                 input logic [1:0] tog);
        sel = ch[1:0];
        #1;
        check_eq($sformatf("%s_ch%0d_status", tag, ch), sel_status, st);
        check_eq($sformatf("%s_ch%0d_cycle", tag, ch), sel_cycle, cyc);
        check_eq($sformatf("%s_ch%0d_toggles", tag, ch), sel_toggles, tog);
    endtask

    task automatic check_verdict(input string tag, input logic exp_pass, input logic [3:0] exp_mask);
        check_eq({tag, "_done"}, done, 1);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_state"}, dbg_state, 2);
        check_eq({tag, "_pass"}, pass, exp_pass);
        check_eq({tag, "_fail_mask"}, fail_mask, exp_mask);
    endtask

    task automatic check_cleared(input string tag);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_pass"}, pass, 0);
        check_eq({tag, "_fail_mask"}, fail_mask, 0);
        check_eq({tag, "_state"}, dbg_state, 0);
        for (int ch = 0; ch < 4; ch++) check_channel(tag, ch, 2'd0, 8'd0, 2'd0);
    endtask

    task automatic start_run(input logic [3:0] led_init);
        nhlt   = 4'hF;
        nerror = 4'hF;
        led    = led_init;
        start  = 1'b1;
        step();
        start  = 1'b0;
    endtask

    // Per-cycle input pattern for each directed scenario, c = counter value.
    task automatic drive_inputs(input int scen, input int c);
        nhlt   = 4'hF;
        nerror = 4'hF;
        led    = 4'h0;
        start  = 1'b0;
        case (scen)
            1: begin
                if (c >= 3) nhlt[0] = 1'b0;
                if (c >= 7) nerror[1] = 1'b0;
                if (c >= 9) nhlt[2] = 1'b0;
                if (c >= 4) begin nhlt[3] = 1'b0; nerror[3] = 1'b0; end
                led[0] = (c >= 1 && c < 5);
                led[1] = (c >= 2 && c < 5);
                led[2] = (c >= 9);
                led[3] = (c >= 6);
                start  = (c == 5);
            end
            2: begin
                nhlt[0] = 1'b0;
                if (c >= 1) nhlt[1] = 1'b0;
                if (c >= 2) nhlt[3] = 1'b0;
            end
            3: begin
                led[0] = (c < 10) ? (c % 2 == 0) : 1'b0;
                led[1] = (c >= 3 && c < 6);
                if (c >= 8)  nhlt[1] = 1'b0;
                if (c >= 10) begin nhlt[0] = 1'b0; nhlt[2] = 1'b0; nhlt[3] = 1'b0; end
            end
            4: begin
                if (c >= 2) nhlt[0] = 1'b0;
            end
            default: ;
        endcase
    endtask

    task automatic run_scenario(input int scen, output int done_at);
        done_at = -1;
        for (int c = 0; c < 40; c++) begin
            drive_inputs(scen, c);
            step();
            if (done) begin
                done_at = c;
                break;
            end
        end
    endtask

    initial begin
        int done_at;
        reset = 1'b1; start = 1'b0; sel = 2'd0;
        nhlt = 4'hF; nerror = 4'hF; led = 4'h0;
        one_start = 1'b0; one_nhlt = 1'b1; one_nerror = 1'b1; one_led = 1'b0; one_sel = 1'b0;
        step(); step();
        check_cleared("reset");
        reset = 1'b0;
        step();

        // Single channel halting at cycle 5.
        one_start = 1'b1;
        step();
        one_start = 1'b0;
        check_eq("one_busy", one_busy, 1);
        done_at = -1;
        for (int c = 0; c < 40; c++) begin
            one_nhlt = (c >= 5) ? 1'b0 : 1'b1;
            step();
            if (one_done) begin done_at = c; break; end
        end
        check_eq("one_done_at", done_at, 5);
        check_eq("one_pass", one_pass, 1);
        check_eq("one_fail_mask", one_fail_mask, 0);
        check_eq("one_status", one_sel_status, 1);
        check_eq("one_cycle", one_sel_cycle, 5);
        one_sel = 1'b1;
        #1;
        check_eq("one_oob_status", one_sel_status, 0);
        check_eq("one_oob_cycle", one_sel_cycle, 0);
        one_sel = 1'b0;

        // Mixed halt/error stops, a stray start mid-run, post-stop toggles.
        start_run(4'h0);
        check_eq("s1_busy", busy, 1);
        check_eq("s1_state_run", dbg_state, 1);
        run_scenario(1, done_at);
        check_eq("s1_done_at", done_at, 9);
        check_verdict("s1", 1'b0, 4'b1010);
        check_channel("s1", 0, 2'd1, 8'd3, 2'd1);
        check_channel("s1", 1, 2'd2, 8'd7, 2'd2);
        check_channel("s1", 2, 2'd1, 8'd9, 2'd1);
        check_channel("s1", 3, 2'd2, 8'd4, 2'd0);
        nhlt = 4'h0; nerror = 4'h0; led = 4'hF;
        step(); step(); step();
        check_verdict("s1_hold", 1'b0, 4'b1010);
        check_channel("s1_hold", 2, 2'd1, 8'd9, 2'd1);
        check_channel("s1_hold", 0, 2'd1, 8'd3, 2'd1);

        // Re-arm from DONE; channel 2 never stops and times out.
        start_run(4'h0);
        check_eq("s2_busy", busy, 1);
        check_eq("s2_done_low", done, 0);
        run_scenario(2, done_at);
        check_eq("s2_done_at", done_at, 19);
        check_verdict("s2", 1'b0, 4'b0100);
        check_channel("s2", 0, 2'd1, 8'd0, 2'd0);
        check_channel("s2", 1, 2'd1, 8'd1, 2'd0);
        check_channel("s2", 2, 2'd3, 8'd19, 2'd0);
        check_channel("s2", 3, 2'd1, 8'd2, 2'd0);

        // Reset asserted at cycle 6 of a run.
        start_run(4'h0);
        for (int c = 0; c <= 6; c++) begin
            drive_inputs(4, c);
            if (c == 6) reset = 1'b1;
            step();
        end
        reset = 1'b0;
        check_cleared("s4");
        step();
        check_eq("s4_stay_idle", dbg_state, 0);

        // Fresh run from IDLE: toggle saturation and an all-halted pass.
        start_run(4'h0);
        run_scenario(3, done_at);
        check_eq("s3_done_at", done_at, 10);
        check_verdict("s3", 1'b1, 4'b0000);
        check_channel("s3", 0, 2'd1, 8'd10, 2'd3);
        check_channel("s3", 1, 2'd1, 8'd8, 2'd2);
        check_channel("s3", 2, 2'd1, 8'd10, 2'd0);
        check_channel("s3", 3, 2'd1, 8'd10, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
